// File: rtl/enc2of5_tx_ctrl.sv
// Two-requester round-robin arbiter feeding a serial 2-of-5 (weights 7-4-2-1-0) BCD digit transmitter.
// Each accepted digit becomes a 5-bit frame, MSB first, followed by GAP idle cycles.
module enc2of5_tx_ctrl #(
    parameter int GAP = 1
) (
    input  logic       CK,
    input  logic       CLRN,
    input  logic       REQ0,
    input  logic [3:0] DIN0,
    output logic       GNT0,
    input  logic       REQ1,
    input  logic [3:0] DIN1,
    output logic       GNT1,
    output logic       SOUT,
    output logic       SVALID,
    output logic       FRAME,
    output logic       BUSY,
    output logic       ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    localparam logic [2:0] GAP_LAST = 3'(GAP - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [4:0] code_q, code_d;
    logic       err_q, err_d;
    logic [3:0] sel_din;

    function automatic logic [4:0] encode(input logic [3:0] digit);
        case (digit)
            4'd0:    encode = 5'b11000;
            4'd1:    encode = 5'b00011;
            4'd2:    encode = 5'b00101;
            4'd3:    encode = 5'b00110;
            4'd4:    encode = 5'b01001;
            4'd5:    encode = 5'b01010;
            4'd6:    encode = 5'b01100;
            4'd7:    encode = 5'b10001;
            4'd8:    encode = 5'b10010;
            4'd9:    encode = 5'b10100;
            default: encode = 5'b00000;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        code_d  = code_q;
        err_d   = 1'b0;
        sel_din = DIN0;
        GNT0    = 1'b0;
        GNT1    = 1'b0;
        SOUT    = 1'b0;
        SVALID  = 1'b0;
        FRAME   = 1'b0;
        BUSY    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grants are gated by CLRN so they read 0 throughout reset, not only after it.
                if (CLRN) begin
                    if (REQ0 && (!REQ1 || last_q)) GNT0 = 1'b1;
                    else if (REQ1)                 GNT1 = 1'b1;
                end
                if (GNT0 || GNT1) begin
                    last_d  = GNT1;
                    sel_din = GNT1 ? DIN1 : DIN0;
                    if (sel_din <= 4'd9) begin
                        state_d = S_SHIFT;
                        cnt_d   = 3'd0;
                        code_d  = encode(sel_din);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                BUSY   = 1'b1;
                SVALID = 1'b1;
                SOUT   = code_q[3'd4 - cnt_q];
                FRAME  = (cnt_q == 3'd0);
                if (cnt_q == 3'd4) begin
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_GAP: begin
                BUSY = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign ERR = err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            last_q  <= 1'b1;
            code_q  <= 5'b00000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_enc2of5_tx_ctrl.sv
// Bench for enc2of5_tx_ctrl: one instance with GAP=1 and one with GAP=0, both compared every
// cycle against a frame-level reference model, plus directed scenario checks.
module tb_enc2of5_tx_ctrl;

    logic       ck;
    logic       clrn;
    logic       req0   [2];
    logic       req1   [2];
    logic [3:0] din0   [2];
    logic [3:0] din1   [2];
    logic       gnt0_o [2];
    logic       gnt1_o [2];
    logic       sout_o [2];
    logic       svalid_o [2];
    logic       frame_o [2];
    logic       busy_o [2];
    logic       err_o  [2];

    enc2of5_tx_ctrl #(.GAP(1)) u_gap1 (
        .CK(ck), .CLRN(clrn),
        .REQ0(req0[0]), .DIN0(din0[0]), .GNT0(gnt0_o[0]),
        .REQ1(req1[0]), .DIN1(din1[0]), .GNT1(gnt1_o[0]),
        .SOUT(sout_o[0]), .SVALID(svalid_o[0]), .FRAME(frame_o[0]),
        .BUSY(busy_o[0]), .ERR(err_o[0])
    );

    enc2of5_tx_ctrl #(.GAP(0)) u_gap0 (
        .CK(ck), .CLRN(clrn),
        .REQ0(req0[1]), .DIN0(din0[1]), .GNT0(gnt0_o[1]),
        .REQ1(req1[1]), .DIN1(din1[1]), .GNT1(gnt1_o[1]),
        .SOUT(sout_o[1]), .SVALID(svalid_o[1]), .FRAME(frame_o[1]),
        .BUSY(busy_o[1]), .ERR(err_o[1])
    );

    always #5 ck = ~ck;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: per instance, the position within the current frame (-1 when idle).
    logic [4:0] code_tab [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                  5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};
    int         gap_of [2] = '{1, 0};
    int         m_pos  [2];
    int         m_last [2];
    logic       m_err  [2];
    logic [4:0] m_code [2];

    logic snap_gnt0 [2];
    logic snap_gnt1 [2];
    logic snap_sout [2];
    logic snap_svalid [2];
    logic snap_frame [2];
    logic snap_busy [2];
    logic snap_err [2];

    logic [4:0] rx_sh;
    int         rx_n;
    logic [4:0] frames_q [$];
    int         fs [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]  = -1;
            m_last[i] = 1;
            m_err[i]  = 1'b0;
            m_code[i] = 5'b0;
        end
        rx_n = 0;
    endtask

    task automatic model_step(input int i);
        logic e_g0, e_g1, e_sout, e_sv, e_fr, e_busy, e_err;
        int   w;
        int   d;
        e_g0 = 0; e_g1 = 0; e_sout = 0; e_sv = 0; e_fr = 0; e_busy = 0;
        e_err = m_err[i];
        m_err[i] = 1'b0;
        if (m_pos[i] >= 0) begin
            e_busy = 1'b1;
            if (m_pos[i] < 5) begin
                e_sv   = 1'b1;
                e_sout = m_code[i][4 - m_pos[i]];
                e_fr   = (m_pos[i] == 0);
            end
            m_pos[i]++;
            if (m_pos[i] == 5 + gap_of[i]) m_pos[i] = -1;
        end else begin
            w = -1;
            if (req0[i] && req1[i]) w = (m_last[i] == 1) ? 0 : 1;
            else if (req0[i])       w = 0;
            else if (req1[i])       w = 1;
            if (w >= 0) begin
                e_g0 = (w == 0);
                e_g1 = (w == 1);
                m_last[i] = w;
                d = (w == 1) ? int'(din1[i]) : int'(din0[i]);
                if (d <= 9) begin
                    m_code[i] = code_tab[d];
                    m_pos[i]  = 0;
                end else begin
                    m_err[i] = 1'b1;
                end
            end
        end
        check($sformatf("i%0d c%0d GNT0", i, cyc), gnt0_o[i], e_g0);
        check($sformatf("i%0d c%0d GNT1", i, cyc), gnt1_o[i], e_g1);
        check($sformatf("i%0d c%0d SOUT", i, cyc), sout_o[i], e_sout);
        check($sformatf("i%0d c%0d SVALID", i, cyc), svalid_o[i], e_sv);
        check($sformatf("i%0d c%0d FRAME", i, cyc), frame_o[i], e_fr);
        check($sformatf("i%0d c%0d BUSY", i, cyc), busy_o[i], e_busy);
        check($sformatf("i%0d c%0d ERR", i, cyc), err_o[i], e_err);
    endtask

    // One clock cycle: sample mid-low-phase, compare with the model, then wait for the next falling edge.
    task automatic tick();
        #2;
        for (int i = 0; i < 2; i++) begin
            snap_gnt0[i]   = gnt0_o[i];
            snap_gnt1[i]   = gnt1_o[i];
            snap_sout[i]   = sout_o[i];
            snap_svalid[i] = svalid_o[i];
            snap_frame[i]  = frame_o[i];
            snap_busy[i]   = busy_o[i];
            snap_err[i]    = err_o[i];
            model_step(i);
        end
        if (svalid_o[0]) begin
            if (frame_o[0]) begin
                rx_n = 0;
                fs.push_back(cyc);
            end
            rx_sh = {rx_sh[3:0], sout_o[0]};
            rx_n++;
            if (rx_n == 5) frames_q.push_back(rx_sh);
        end
        cyc++;
        @(negedge ck);
    endtask

    task automatic check_quiet(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s i%0d GNT0", tag, i), gnt0_o[i], 1'b0);
            check($sformatf("%s i%0d GNT1", tag, i), gnt1_o[i], 1'b0);
            check($sformatf("%s i%0d SOUT", tag, i), sout_o[i], 1'b0);
            check($sformatf("%s i%0d SVALID", tag, i), svalid_o[i], 1'b0);
            check($sformatf("%s i%0d FRAME", tag, i), frame_o[i], 1'b0);
            check($sformatf("%s i%0d BUSY", tag, i), busy_o[i], 1'b0);
            check($sformatf("%s i%0d ERR", tag, i), err_o[i], 1'b0);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            req0[i] = 1'b0; req1[i] = 1'b0; din0[i] = 4'd0; din1[i] = 4'd0;
        end
    endtask

    // Entered and left at a falling edge; reset is held across one rising edge.
    task automatic do_reset(input string tag);
        clrn = 1'b0;
        #1;
        check_quiet(tag);
        @(negedge ck);
        clrn = 1'b1;
        model_reset();
    endtask

    logic [4:0] code7;

    initial begin
        ck   = 1'b0;
        clrn = 1'b1;
        clear_inputs();
        model_reset();
        code7 = 5'b10001;

        // Reset with both requests pending: every output must read 0.
        #1 clrn = 1'b0;
        req0[0] = 1'b1; req1[0] = 1'b1; req0[1] = 1'b1;
        @(negedge ck);
        @(negedge ck);
        #1;
        check_quiet("reset");
        clear_inputs();

        // Digit 3 from requester 0, granted on the first edge after release.
        @(negedge ck);
        clrn = 1'b1;
        model_reset();
        req0[0] = 1'b1; din0[0] = 4'd3;
        tick();
        check("r028 first GNT0", snap_gnt0[0], 1'b1);
        req0[0] = 1'b0;
        frames_q.delete();
        repeat (7) tick();
        check("r028 frame count", frames_q.size(), 1);
        check("r028 frame bits", frames_q.size() > 0 ? frames_q[0] : 5'h1f, 5'b00110);

        // Both requesters held: alternating frames starting with requester 0, 7 cycles apart.
        do_reset("r029 reset");
        frames_q.delete();
        fs.delete();
        req0[0] = 1'b1; din0[0] = 4'd0;
        req1[0] = 1'b1; din1[0] = 4'd9;
        repeat (28) tick();
        clear_inputs();
        repeat (8) tick();
        check("r029 frame count", frames_q.size(), 4);
        for (int k = 0; k < frames_q.size(); k++)
            check($sformatf("r029 frame %0d", k), frames_q[k], (k % 2 == 0) ? 5'b11000 : 5'b10100);
        for (int k = 1; k < fs.size(); k++)
            check($sformatf("r029 spacing %0d", k), fs[k] - fs[k-1], 7);

        // Illegal digit from requester 1: grant, ERR next cycle, no frame, tie then goes to 0.
        req1[0] = 1'b1; din1[0] = 4'd12;
        tick();
        check("r030 GNT1", snap_gnt1[0], 1'b1);
        req1[0] = 1'b0;
        tick();
        check("r030 ERR", snap_err[0], 1'b1);
        check("r030 SVALID", snap_svalid[0], 1'b0);
        check("r030 BUSY", snap_busy[0], 1'b0);
        req0[0] = 1'b1; din0[0] = 4'd1;
        req1[0] = 1'b1; din1[0] = 4'd2;
        tick();
        check("r030 tie GNT0", snap_gnt0[0], 1'b1);
        clear_inputs();
        repeat (8) tick();

        // Reset during the third bit aborts the frame; afterwards a tie goes to requester 0.
        req0[0] = 1'b1; din0[0] = 4'd5;
        tick();
        req0[0] = 1'b0;
        tick();
        tick();
        #2;
        check("r031 SVALID before", svalid_o[0], 1'b1);
        clrn = 1'b0;
        #1;
        check("r031 SVALID", svalid_o[0], 1'b0);
        check("r031 BUSY", busy_o[0], 1'b0);
        check("r031 FRAME", frame_o[0], 1'b0);
        req0[0] = 1'b1; din0[0] = 4'd0;
        req1[0] = 1'b1; din1[0] = 4'd9;
        @(negedge ck);
        #1;
        check_quiet("r031 held");
        clrn = 1'b1;
        model_reset();
        tick();
        check("r031 tie GNT0", snap_gnt0[0], 1'b1);
        clear_inputs();
        repeat (8) tick();

        // GAP=0 instance: digit 7 held, frames every 6 cycles with one grant cycle between.
        do_reset("r032 reset");
        req0[1] = 1'b1; din0[1] = 4'd7;
        for (int k = 0; k < 18; k++) begin
            tick();
            check($sformatf("r032 GNT0 k%0d", k), snap_gnt0[1], (k % 6 == 0));
            check($sformatf("r032 SVALID k%0d", k), snap_svalid[1], (k % 6 != 0));
            check($sformatf("r032 FRAME k%0d", k), snap_frame[1], (k % 6 == 1));
            if (k % 6 != 0)
                check($sformatf("r032 SOUT k%0d", k), snap_sout[1], code7[4 - (k % 6 - 1)]);
        end
        clear_inputs();
        repeat (7) tick();

        // Random traffic on both instances, including illegal digits and dropped requests.
        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                req0[i] = ($urandom_range(0, 2) != 0);
                req1[i] = ($urandom_range(0, 2) != 0);
                din0[i] = 4'($urandom_range(0, 11));
                din1[i] = 4'($urandom_range(0, 11));
            end
            tick();
        end
        clear_inputs();
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/enc2of5_tx_ctrl.md
ENC2OF5_TX_CTRL -- requirements
Module: enc2of5_tx_ctrl

Interface
REQ-001 The block SHALL have parameter GAP, default 1, giving the idle cycles (0-7) inserted after each transmitted frame.
REQ-002 The block SHALL have port CK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port CLRN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port REQ0, input, 1 bit: requester 0 holds a digit.
REQ-005 The block SHALL have port DIN0, input, 4 bits: requester 0 BCD digit.
REQ-006 The block SHALL have port GNT0, output, 1 bit: requester 0 granted this cycle.
REQ-007 The block SHALL have ports REQ1, input, 1 bit; DIN1, input, 4 bits; GNT1, output, 1 bit: the same roles for requester 1.
REQ-008 The block SHALL have port SOUT, output, 1 bit: serial 2-of-5 code bit.
REQ-009 The block SHALL have port SVALID, output, 1 bit: SOUT carries a valid code bit.
REQ-010 The block SHALL have port FRAME, output, 1 bit: high on the first bit of each frame.
REQ-011 The block SHALL have port BUSY, output, 1 bit: state is not IDLE.
REQ-012 The block SHALL have port ERR, output, 1 bit: one-cycle pulse on an illegal digit.

Function
REQ-013 The state machine SHALL have exactly three states, IDLE, SHIFT and GAP, with a 3-bit cycle counter CNT.
REQ-014 In IDLE with any REQ high, the block SHALL assert exactly one GNT combinationally; a transfer occurs at the rising CK where REQx&GNTx=1, capturing DINx.
REQ-015 Arbitration SHALL be round-robin: if only one REQ is high, that requester wins; if both are high, the requester not granted last wins; pointer LAST SHALL update on every transfer.
REQ-016 GNT0 and GNT1 SHALL be 0 outside IDLE, and SHALL never both be 1.
REQ-017 The encoding SHALL use weights 7-4-2-1-0, code[4:0]: 0=11000, 1=00011, 2=00101, 3=00110, 4=01001, 5=01010, 6=01100, 7=10001, 8=10010, 9=10100.
REQ-018 On a legal transfer, the next state SHALL be SHIFT with CNT=0.
REQ-019 In SHIFT, the block SHALL drive SOUT=code[4-CNT] and SVALID=1, with FRAME=1 only at CNT=0; the first bit SHALL appear one cycle after the transfer edge.
REQ-020 After CNT=4, the block SHALL go to GAP for GAP cycles when GAP>0, else to IDLE; frame period SHALL be 1+5+GAP cycles.
REQ-021 In GAP and IDLE, SOUT, SVALID and FRAME SHALL be 0.
REQ-022 A digit >9 SHALL still complete the transfer and advance LAST, SHALL pulse ERR high in the following cycle, SHALL send no frame, and SHALL leave the state in IDLE.
REQ-023 A REQ dropped before a grant SHALL be ignored without error.
REQ-024 BUSY SHALL be high in SHIFT and GAP.

Reset
REQ-025 CLRN=0 SHALL immediately force IDLE, CNT=0, LAST=1 (requester 0 wins the first tie), and GNT0, GNT1, SOUT, SVALID, FRAME, BUSY and ERR all to 0, independent of CK.
REQ-026 A reset during SHIFT SHALL abort the frame with no further SVALID, and SHALL discard the captured digit.
REQ-027 The first transfer SHALL be possible at the first rising CK after CLRN returns high.

Verification
REQ-028 Reset release, REQ0=1 with DIN0=3 -> GNT0=1 for 1 cycle; then SVALID for 5 cycles with SOUT=0,0,1,1,0 and FRAME on the first bit only.
REQ-029 REQ0 and REQ1 both held high, DIN0=0, DIN1=9 -> frames alternate 11000 (req0 first), 10100, ...; with GAP=1 each frame starts 7 cycles after the previous one.
REQ-030 REQ1=1 with DIN1=12 -> GNT1 pulse, ERR=1 the next cycle, SVALID stays 0, BUSY stays 0; the next tie is won by requester 0.
REQ-031 CLRN pulsed low at the third bit of a frame -> SVALID, BUSY and FRAME drop immediately; after release, a pending REQ1 tie is won by requester 0.
REQ-032 GAP=0, REQ0 held high with DIN0=7 -> frames 10001 repeat every 6 cycles, with GNT0 only in the single IDLE cycle between frames.
